mem_xfer_ctrl: RTL and testbench
================================

MEM_XFER_CTRL -- requirements
Module: mem_xfer_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1: one-cycle request to begin a transfer; ignored while busy=1.
REQ-004 SHALL have port dir, input, 1: 0 = load (memory to V0..Vx, Fx65); 1 = store (V0..Vx to memory, Fx55).
REQ-005 SHALL have port last_reg, input, 4: x, the highest register index transferred.
REQ-006 SHALL have port i_reg, input, 12: base address I.
REQ-007 SHALL have port reg_file_in, input, 128: packed V registers, V0 in [7:0], V15 in [127:120].
REQ-008 SHALL have port mem_read_buffer, input, 128: packed bytes from the memory side, same packing.
REQ-009 SHALL have port mem_address, output, 12: base address presented to memory.
REQ-010 SHALL have port mem_counter, output, 4: byte offset k; memory accesses address mem_address+k.
REQ-011 SHALL have port mem_write_enable, output, 1: memory write strobe.
REQ-012 SHALL have port mem_write_count, output, 4: last valid offset of a store.
REQ-013 SHALL have port mem_write_buffer, output, 128: store data, same packing as reg_file_in.
REQ-014 SHALL have port load_data, output, 128: loaded bytes, same packing.
REQ-015 SHALL have port load_mask, output, 16: bit n set = Vn is updated from load_data.
REQ-016 SHALL have port load_valid, output, 1: one-cycle pulse qualifying load_data/load_mask.
REQ-017 SHALL have port busy, output, 1: high from the cycle after accepted start until done.
REQ-018 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-019 SHALL implement states IDLE, STORE, LOAD, SETTLE, DONE.
REQ-020 SHALL, in IDLE on start=1, latch dir, last_reg, i_reg and reg_file_in, set mem_counter=0, and go to STORE (dir=1) or LOAD (dir=0).
REQ-021 SHALL, in STORE, hold mem_write_enable=1, drive mem_write_buffer and mem_write_count from the latched values, and increment mem_counter by one per cycle.
REQ-022 SHALL leave STORE for DONE on the cycle mem_counter equals latched x, giving exactly x+1 write cycles.
REQ-023 SHALL, in LOAD, hold mem_write_enable=0 and increment mem_counter by one per cycle, moving to SETTLE on the cycle mem_counter equals x.
REQ-024 SHALL spend exactly one cycle in SETTLE for the memory side's registered read, then go to DONE.
REQ-025 SHALL, on entry to DONE after a load, capture mem_read_buffer into load_data, set load_mask bits 0..x, and pulse load_valid with done.
REQ-026 SHALL pulse done for one cycle in DONE, then return to IDLE; start in DONE is ignored.
REQ-027 SHALL never wrap mem_counter: x=15 ends at k=15 with no 16th access.
REQ-028 SHALL treat mem_address+k as modulo 4096 (I=0xFFF, k=1 accesses 0x000).
REQ-029 SHALL be unaffected by changes to dir, last_reg, i_reg or reg_file_in after acceptance.
REQ-030 SHALL never assert mem_write_enable outside STORE.

Reset
REQ-031 SHALL, on reset=1 at a rising edge, enter IDLE and clear busy, done, load_valid, mem_write_enable, mem_counter, mem_address, mem_write_count, load_mask, load_data and mem_write_buffer to 0.
REQ-032 SHALL abort any transfer on reset mid-operation, with mem_write_enable low from the next cycle and no load_valid or done pulse.
REQ-033 SHALL give reset priority over a simultaneous start.

Configuration
REQ-034 SHALL, with MEM_XFER_I_INCREMENT_EN defined, add outputs i_update (12) and i_update_valid (1), pulsing i_update_valid with done and setting i_update = latched I + x + 1 mod 4096 (original CHIP-8 behaviour).
REQ-035 SHALL, without MEM_XFER_I_INCREMENT_EN, omit both ports and leave I unmodified.

Verification
REQ-036 Store I=0x300, x=3, V0..V3=11,22,33,44 -> write_enable high 4 cycles, k=0..3, done at cycle 5.
REQ-037 Load I=0x200, x=0, memory[0x200]=0xA5 -> load_valid with load_data[7:0]=0xA5, load_mask=0x0001.
REQ-038 Load x=15, I=0xFF8 -> k=0..15 addresses wrap to 0x000..0x007, load_mask=0xFFFF, one SETTLE cycle.
REQ-039 Reset asserted at k=2 of store x=7 -> write_enable low next cycle, no done, busy=0.
REQ-040 Start re-pulsed while busy, and on the same cycle as reset -> both ignored, no second transfer.
REQ-041 With MEM_XFER_I_INCREMENT_EN, store I=0xFFE, x=2 -> i_update=0x001, pulsed with done.

Source files
------------

// File: rtl/mem_xfer_ctrl.sv
// ============================================================================
//  Module   : mem_xfer_ctrl
//  Purpose  : Moves V0..Vx between the register file and memory at base I
//             (store Fx55 / load Fx65). Optional I post-increment is enabled
//             with macro MEM_XFER_I_INCREMENT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_xfer_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         dir,
  input  logic [3:0]   last_reg,
  input  logic [11:0]  i_reg,
  input  logic [127:0] reg_file_in,
  input  logic [127:0] mem_read_buffer,
  output logic [11:0]  mem_address,
  output logic [3:0]   mem_counter,
  output logic         mem_write_enable,
  output logic [3:0]   mem_write_count,
  output logic [127:0] mem_write_buffer,
  output logic [127:0] load_data,
  output logic [15:0]  load_mask,
  output logic         load_valid,
  output logic         busy,
  output logic         done
`ifdef MEM_XFER_I_INCREMENT_EN
  ,
  output logic [11:0]  i_update,
  output logic         i_update_valid
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STORE  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t         r_state;
  logic [3:0]     r_last;
  logic [11:0]    r_addr;
  logic [3:0]     r_counter;
  logic           r_we;
  logic [127:0]   r_wbuf;
  logic [127:0]   r_load_data;
  logic [15:0]    r_load_mask;
  logic           r_load_valid;
  logic           r_busy;
  logic           r_done;
  logic [15:0]    w_mask;
  logic           w_at_last;

  // Bits 0..x set: shift a full mask right by the number of unused registers.
  assign w_mask    = 16'hFFFF >> (4'd15 - r_last);
  assign w_at_last = (r_counter == r_last);

`ifdef MEM_XFER_I_INCREMENT_EN
  logic [11:0]    r_i_update;
  logic           r_i_update_valid;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last       <= 4'd0;
      r_addr       <= 12'd0;
      r_counter    <= 4'd0;
      r_we         <= 1'b0;
      r_wbuf       <= 128'd0;
      r_load_data  <= 128'd0;
      r_load_mask  <= 16'd0;
      r_load_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef MEM_XFER_I_INCREMENT_EN
      r_i_update       <= 12'd0;
      r_i_update_valid <= 1'b0;
`endif
    end else begin
      r_done       <= 1'b0;
      r_load_valid <= 1'b0;
`ifdef MEM_XFER_I_INCREMENT_EN
      r_i_update_valid <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_last    <= last_reg;
            r_addr    <= i_reg;
            r_wbuf    <= reg_file_in;
            r_counter <= 4'd0;
            r_busy    <= 1'b1;
`ifdef MEM_XFER_I_INCREMENT_EN
            r_i_update <= i_reg + {8'd0, last_reg} + 12'd1;
`endif
            if (dir) begin
              r_state <= ST_STORE;
              r_we    <= 1'b1;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end

        ST_STORE: begin
          if (w_at_last) begin
            r_we    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
`ifdef MEM_XFER_I_INCREMENT_EN
            r_i_update_valid <= 1'b1;
`endif
          end else begin
            r_counter <= r_counter + 4'd1;
          end
        end

        ST_LOAD: begin
          if (w_at_last) begin
            r_state <= ST_SETTLE;
          end else begin
            r_counter <= r_counter + 4'd1;
          end
        end

        // Memory registers its read, so the last byte lands one cycle later.
        ST_SETTLE: begin
          r_load_data  <= mem_read_buffer;
          r_load_mask  <= w_mask;
          r_load_valid <= 1'b1;
          r_done       <= 1'b1;
          r_state      <= ST_DONE;
`ifdef MEM_XFER_I_INCREMENT_EN
          r_i_update_valid <= 1'b1;
`endif
        end

        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_address      = r_addr;
  assign mem_counter      = r_counter;
  assign mem_write_enable = r_we;
  assign mem_write_count  = r_last;
  assign mem_write_buffer = r_wbuf;
  assign load_data        = r_load_data;
  assign load_mask        = r_load_mask;
  assign load_valid       = r_load_valid;
  assign busy             = r_busy;
  assign done             = r_done;
`ifdef MEM_XFER_I_INCREMENT_EN
  assign i_update         = r_i_update;
  assign i_update_valid   = r_i_update_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_xfer_ctrl.sv
// ============================================================================
//  Module   : tb_mem_xfer_ctrl
//  Purpose  : Directed self-checking bench for mem_xfer_ctrl with a byte
//             memory model that has a registered read path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_xfer_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         dir = 1'b0;
  logic [3:0]   last_reg = 4'd0;
  logic [11:0]  i_reg = 12'd0;
  logic [127:0] reg_file_in = 128'd0;
  logic [127:0] mem_read_buffer = 128'd0;
  logic [11:0]  mem_address;
  logic [3:0]   mem_counter;
  logic         mem_write_enable;
  logic [3:0]   mem_write_count;
  logic [127:0] mem_write_buffer;
  logic [127:0] load_data;
  logic [15:0]  load_mask;
  logic         load_valid;
  logic         busy;
  logic         done;
`ifdef MEM_XFER_I_INCREMENT_EN
  logic [11:0]  i_update;
  logic         i_update_valid;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mem_xfer_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .dir              (dir),
    .last_reg         (last_reg),
    .i_reg            (i_reg),
    .reg_file_in      (reg_file_in),
    .mem_read_buffer  (mem_read_buffer),
    .mem_address      (mem_address),
    .mem_counter      (mem_counter),
    .mem_write_enable (mem_write_enable),
    .mem_write_count  (mem_write_count),
    .mem_write_buffer (mem_write_buffer),
    .load_data        (load_data),
    .load_mask        (load_mask),
    .load_valid       (load_valid),
    .busy             (busy),
    .done             (done)
`ifdef MEM_XFER_I_INCREMENT_EN
    ,
    .i_update         (i_update),
    .i_update_valid   (i_update_valid)
`endif
  );

  always #5 clk = ~clk;

  // Default memory contents; 0x200 holds 0xA5.
  function automatic logic [7:0] mem_init_val(input logic [11:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  logic [7:0]  mem [0:4095];
  logic        mem_init = 1'b1;
  logic [11:0] w_acc_addr;
  assign w_acc_addr = mem_address + {8'd0, mem_counter};

  always @(posedge clk) begin
    if (mem_init) begin
      for (int a = 0; a < 4096; a++) mem[a] <= mem_init_val(12'(a));
    end else if (mem_write_enable) begin
      mem[w_acc_addr] <= mem_write_buffer[{mem_counter, 3'b000} +: 8];
    end
    mem_read_buffer[{mem_counter, 3'b000} +: 8] <= mem[w_acc_addr];
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accepts one transfer, scrambles the inputs, and runs until done (bounded).
  task automatic run_xfer(input logic d, input logic [3:0] x, input logic [11:0] base,
                          input logic [127:0] regs, output int done_cyc, output int we_cycles);
    @(negedge clk);
    dir = d; last_reg = x; i_reg = base; reg_file_in = regs; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dir = ~d; last_reg = ~x; i_reg = ~base; reg_file_in = ~regs;
    done_cyc  = -1;
    we_cycles = 0;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      if (c > 1) @(negedge clk);
      if (c <= int'(x) + 1) check("counter_seq", 128'(mem_counter), 128'(c - 1));
      if (mem_write_enable) we_cycles++;
      if (done) done_cyc = c;
    end
    if (done_cyc < 0) check("done_timeout", 128'd0, 128'd1);
  endtask

  initial begin
    int dc, wc, nd;
    logic [127:0] exp_data;

    // Reset state
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    check("rst_busy",  128'(busy), 128'd0);
    check("rst_done",  128'(done), 128'd0);
    check("rst_lv",    128'(load_valid), 128'd0);
    check("rst_we",    128'(mem_write_enable), 128'd0);
    check("rst_cnt",   128'(mem_counter), 128'd0);
    check("rst_addr",  128'(mem_address), 128'd0);
    check("rst_wcnt",  128'(mem_write_count), 128'd0);
    check("rst_mask",  128'(load_mask), 128'd0);
    check("rst_ldata", load_data, 128'd0);
    check("rst_wbuf",  mem_write_buffer, 128'd0);
    reset = 1'b0;

    // Store I=0x300, x=3
    run_xfer(1'b1, 4'd3, 12'h300, {96'd0, 32'h44332211}, dc, wc);
    check("st_done_cyc", 128'(dc), 128'd5);
    check("st_we_cycles", 128'(wc), 128'd4);
    check("st_busy_in_done", 128'(busy), 128'd1);
    check("st_wcount", 128'(mem_write_count), 128'd3);
    check("st_lv", 128'(load_valid), 128'd0);
    @(negedge clk);
    check("st_done_pulse", 128'(done), 128'd0);
    check("st_idle_busy", 128'(busy), 128'd0);
    check("st_mem0", 128'(mem[12'h300]), 128'h11);
    check("st_mem1", 128'(mem[12'h301]), 128'h22);
    check("st_mem2", 128'(mem[12'h302]), 128'h33);
    check("st_mem3", 128'(mem[12'h303]), 128'h44);
    check("st_mem4_untouched", 128'(mem[12'h304]), 128'hA1);

    // Load I=0x200, x=0
    run_xfer(1'b0, 4'd0, 12'h200, 128'hDEAD, dc, wc);
    check("ld0_done_cyc", 128'(dc), 128'd3);
    check("ld0_we", 128'(wc), 128'd0);
    check("ld0_lv", 128'(load_valid), 128'd1);
    check("ld0_byte", 128'(load_data[7:0]), 128'hA5);
    check("ld0_mask", 128'(load_mask), 128'h0001);

    // Load I=0xFF8, x=15: addresses wrap past 0xFFF
    exp_data = '0;
    for (int k = 0; k < 16; k++) exp_data[k*8 +: 8] = mem_init_val(12'hFF8 + 12'(k));
    run_xfer(1'b0, 4'd15, 12'hFF8, 128'd0, dc, wc);
    check("ld15_done_cyc", 128'(dc), 128'd18);
    check("ld15_addr", 128'(mem_address), 128'hFF8);
    check("ld15_cnt_nowrap", 128'(mem_counter), 128'd15);
    check("ld15_data", load_data, exp_data);
    check("ld15_mask", 128'(load_mask), 128'hFFFF);
    check("ld15_lv", 128'(load_valid), 128'd1);

    // Reset at k=2 of store x=7
    @(negedge clk);
    dir = 1'b1; last_reg = 4'd7; i_reg = 12'h100; reg_file_in = {128{1'b1}}; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_k2", 128'(mem_counter), 128'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_we", 128'(mem_write_enable), 128'd0);
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_addr", 128'(mem_address), 128'd0);
    nd = 0; wc = 0;
    for (int c = 0; c < 12; c++) begin
      if (done || load_valid) nd++;
      if (mem_write_enable) wc++;
      @(negedge clk);
    end
    check("abort_no_done", 128'(nd), 128'd0);
    check("abort_no_we", 128'(wc), 128'd0);

    // Start held through busy and DONE: only one transfer
    dir = 1'b1; last_reg = 4'd1; i_reg = 12'h400; reg_file_in = 128'h5566; start = 1'b1;
    nd = 0; wc = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) dir = 1'b0;
      if (c == 4) start = 1'b0;
      if (done) nd++;
      if (mem_write_enable) wc++;
    end
    check("rep_done_count", 128'(nd), 128'd1);
    check("rep_we_count", 128'(wc), 128'd2);
    check("rep_busy_end", 128'(busy), 128'd0);

    // Start coincident with reset
    dir = 1'b1; last_reg = 4'd2; start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    check("rs_busy", 128'(busy), 128'd0);
    check("rs_we", 128'(mem_write_enable), 128'd0);
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done || busy || mem_write_enable) nd++;
    end
    check("rs_no_xfer", 128'(nd), 128'd0);

`ifdef MEM_XFER_I_INCREMENT_EN
    run_xfer(1'b1, 4'd2, 12'hFFE, 128'h0, dc, wc);
    check("iinc_valid", 128'(i_update_valid), 128'd1);
    check("iinc_value", 128'(i_update), 128'h001);
    @(negedge clk);
    check("iinc_pulse", 128'(i_update_valid), 128'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
